icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Read-only direct-mapped L1 instruction cache between the pipeline's ICACHE port and
//  instruction memory. Serves 32-bit word fetches combinationally on hit; on miss stalls
//  the pipeline, fetches one 4-word (128-bit) block over a ready-handshaked memory port
//  and refills. Sits directly downstream of the fetch stage; the pipeline's ICACHE_stall is driven by proc_stall.
// PARAMETERS
//  NUM_BLOCKS  8   cache lines; power of 2; IDX_W = log2(NUM_BLOCKS)
//  WORDS       4   32-bit words per line (fixed; offset = proc_addr[1:0])
// PORTS
//  clk         in   1    single clock, all state updates on rising edge
//  rst         in   1    synchronous, active-high reset
//  proc_read   in   1    fetch request for the word at proc_addr
//  proc_write  in   1    write request; unsupported, ignored
//  proc_addr   in   30   word address: tag=[29:2+IDX_W], index=[1+IDX_W:2], offset=[1:0]
//  proc_wdata  in   32   unused
//  proc_rdata  out  32   fetched instruction word
//  proc_stall  out  1    1 = request not yet served; pipeline holds
//  mem_read    out  1    block read request to memory
//  mem_write   out  1    tied 0
//  mem_addr    out  28   block address = proc_addr[29:2]
//  mem_wdata   out  128  tied 0
//  mem_rdata   in   128  returned block; word k at [32k+31:32k]
//  mem_ready   in   1    1-cycle pulse: mem_rdata valid, request complete
// BEHAVIOUR
//  Storage: per line valid bit, tag (30-2-IDX_W bits), 128-bit data; registers, no SRAM.
//  Reset: all valid=0, state=IDLE, mem_read=0, proc_stall=0, proc_rdata=0; perf counters=0.
//  FSM states IDLE, FETCH, FILL.
//   IDLE: hit = proc_read & valid[idx] & tag match. Hit -> proc_rdata = line word[offset]
//     same cycle, proc_stall=0 (0-cycle latency). Miss -> proc_stall=1 combinationally,
//     next state FETCH. proc_read=0 -> proc_stall=0, proc_rdata holds last value.
//   FETCH: mem_read=1, mem_addr=proc_addr[29:2], held stable until mem_ready sampled high;
//     proc_stall=1. On mem_ready: write mem_rdata to line idx, set tag, valid=1, mem_read
//     drops next cycle, go FILL.
//   FILL: proc_stall=1 for this one cycle; proc_rdata = new line word[offset]; -> IDLE,
//     where the retry hits. Miss penalty = memory latency + 2 cycles.
//  proc_addr must stay stable while proc_stall=1 (pipeline guarantee); not checked.
//  Miss replaces valid line with different tag unconditionally (read-only, no writeback).
//  mem_ready while in IDLE/FILL: ignored. proc_write=1: no state change, no stall.
//  proc_read and proc_write both 1: treated as read.
//  rst mid-FETCH: request abandoned, mem_read=0 next cycle, all lines invalid; a late
//  mem_ready after reset is ignored (state IDLE).
//  Index wrap: addresses differing only in tag alias to same line (thrash by design).
// CONFIGURATION
//  ICACHE_PERF_EN defined: adds outputs perf_hits[31:0], perf_misses[31:0]; hits counts
//   IDLE cycles with a hit, misses counts IDLE->FETCH transitions; retry hit after FILL
//   counts as a hit; both saturate at 32'hFFFF_FFFF; cleared by rst.
//  ICACHE_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rst then proc_read, addr 30'h10 -> stall=1, mem_read=1, mem_addr=28'h4; mem_ready
//    after 3 cycles with rdata {D3,D2,D1,D0} -> FILL then hit, proc_rdata=D0, stall=0.
//  2 after 1, addrs 30'h11,12,13 back-to-back -> D1,D2,D3, stall=0, no mem_read.
//  3 conflict: addr 30'h30 (same idx 4, new tag) -> miss, refill; then 30'h10 misses again.
//  4 rst asserted in FETCH, then mem_ready pulse -> mem_read=0, no line valid, 30'h10
//    misses afresh.
//  5 proc_write=1, proc_read=0 -> stall=0, mem_read=0, mem_write=0, cache unchanged.
//  6 ICACHE_PERF_EN: scenarios 1+2 -> perf_misses=1, perf_hits=4.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache: 0-cycle hits, blocking single-block refill on miss.
// Define ICACHE_PERF_EN to add saturating perf_hits / perf_misses counters.
module icache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int WORDS      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [32*WORDS-1:0] mem_wdata,
  input  logic [32*WORDS-1:0] mem_rdata,
  input  logic          mem_ready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   perf_hits,
  output logic [31:0]   perf_misses
`endif
);

  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t                  state;
  logic [NUM_BLOCKS-1:0]   valid;
  logic [TAG_W-1:0]        tags  [NUM_BLOCKS];
  logic [LINE_W-1:0]       lines [NUM_BLOCKS];
  logic [31:0]             rdata_q;

  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              off;
  logic                    hit;
  logic                    miss;
  logic [LINE_W-1:0]       cur_line;
  logic [31:0]             cur_word;

  // Writes are not supported; these inputs exist only for port compatibility.
  logic unused_inputs;
  assign unused_inputs = proc_write ^ (^proc_wdata);

  assign idx      = proc_addr[IDX_W+1:2];
  assign tag      = proc_addr[29:IDX_W+2];
  assign off      = proc_addr[1:0];
  assign fill_idx = mem_addr[IDX_W-1:0];

  assign hit      = (state == IDLE) && proc_read && valid[idx] && (tags[idx] == tag);
  assign miss     = (state == IDLE) && proc_read && !hit;
  assign cur_line = lines[idx];
  assign cur_word = cur_line[{off, 5'd0} +: 32];

  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  always_comb begin
    proc_rdata = rdata_q;
    if (hit || state == FILL) proc_rdata = cur_word;
  end

  assign proc_stall = miss || (state == FETCH) || (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
      rdata_q  <= '0;
      valid    <= '0;
    end else begin
      rdata_q <= proc_rdata;
      case (state)
        IDLE: begin
          if (miss) begin
            state    <= FETCH;
            mem_read <= 1'b1;
            mem_addr <= proc_addr[29:2];
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state           <= FILL;
            mem_read        <= 1'b0;
            valid[fill_idx] <= 1'b1;
          end
        end
        FILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (!rst && state == FETCH && mem_ready) begin
      tags[fill_idx]  <= mem_addr[27:IDX_W];
      lines[fill_idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit && perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
      if (miss && perf_misses != 32'hFFFF_FFFF) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: cycle-level cache model compared every cycle, plus directed literal checks.
module tb_icache_direct_mapped;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          proc_read = 1'b0;
  logic          proc_write = 1'b0;
  logic [29:0]   proc_addr = '0;
  logic [31:0]   proc_wdata = 32'hDEAD_BEEF;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata = '0;
  logic          mem_ready = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;
`endif

  icache_direct_mapped dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef ICACHE_PERF_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] BLK_A = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  localparam logic [127:0] BLK_B = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
  localparam logic [127:0] BLK_C = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: actual %h required %h", name, got, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] k);
    logic [127:0] s;
    s = blk >> (32 * int'(k));
    return s[31:0];
  endfunction

  // Model: cache contents plus "memory request outstanding" and "refill just landed".
  logic          m_valid [8];
  logic [24:0]   m_tag   [8];
  logic [127:0]  m_data  [8];
  logic          m_req = 1'b0;
  logic          m_fill = 1'b0;
  logic          started = 1'b0;
  logic [27:0]   m_addr = '0;
  logic [31:0]   m_last = '0;
  logic [31:0]   m_hits = '0;
  logic [31:0]   m_misses = '0;
  logic          exp_hit = 1'b0;
  logic          exp_stall;
  logic [31:0]   exp_rdata = '0;
  int            ci;
  int            li;

  always @(negedge clk) begin
    if (started) begin
      ci        = int'(proc_addr[4:2]);
      exp_hit   = !m_req && !m_fill && proc_read && m_valid[ci] && (m_tag[ci] == proc_addr[29:5]);
      exp_stall = m_req || m_fill || (proc_read && !exp_hit);
      exp_rdata = (exp_hit || m_fill) ? word_of(m_data[ci], proc_addr[1:0]) : m_last;
      chk("model_stall", {127'd0, proc_stall}, {127'd0, exp_stall});
      chk("model_rdata", {96'd0, proc_rdata}, {96'd0, exp_rdata});
      chk("model_mem_read", {127'd0, mem_read}, {127'd0, m_req});
      chk("model_mem_write", {127'd0, mem_write}, 128'd0);
      chk("model_mem_wdata", mem_wdata, 128'd0);
      if (m_req) chk("model_mem_addr", {100'd0, mem_addr}, {100'd0, m_addr});
`ifdef ICACHE_PERF_EN
      chk("model_perf_hits", {96'd0, perf_hits}, {96'd0, m_hits});
      chk("model_perf_misses", {96'd0, perf_misses}, {96'd0, m_misses});
`endif
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      started  = 1'b1;
      m_req    = 1'b0;
      m_fill   = 1'b0;
      m_last   = '0;
      m_hits   = '0;
      m_misses = '0;
      for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
    end else if (started) begin
      m_last = exp_rdata;
      if (m_req) begin
        if (mem_ready) begin
          li         = int'(m_addr[2:0]);
          m_valid[li] = 1'b1;
          m_tag[li]   = m_addr[27:3];
          m_data[li]  = mem_rdata;
          m_req       = 1'b0;
          m_fill      = 1'b1;
        end
      end else if (m_fill) begin
        m_fill = 1'b0;
      end else if (exp_hit) begin
        if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
      end else if (proc_read) begin
        m_req  = 1'b1;
        m_addr = proc_addr[29:2];
        if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the block request, then returns blk in the lat-th request cycle.
  task automatic serve(input logic [127:0] blk, input int lat);
    int n;
    n = 0;
    while (!mem_read && n < 20) begin
      tick();
      n++;
    end
    chk("serve_mem_read_seen", {127'd0, mem_read}, 128'd1);
    repeat (lat - 1) tick();
    mem_ready = 1'b1;
    mem_rdata = blk;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {127'd0, proc_stall}, 128'd0);
    chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
    chk("rst_rdata", {96'd0, proc_rdata}, 128'd0);

    // Cold miss at 0x10, memory answers in the third request cycle.
    tick();
    proc_read = 1'b1;
    proc_addr = 30'h10;
    @(negedge clk);
    chk("s1_miss_stall", {127'd0, proc_stall}, 128'd1);
    chk("s1_miss_no_mem_read_yet", {127'd0, mem_read}, 128'd0);
    tick();
    @(negedge clk);
    chk("s1_fetch_mem_read", {127'd0, mem_read}, 128'd1);
    chk("s1_fetch_mem_addr", {100'd0, mem_addr}, {100'd0, 28'h4});
    tick();
    tick();
    mem_ready = 1'b1;
    mem_rdata = BLK_A;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(negedge clk);
    chk("s1_fill_stall", {127'd0, proc_stall}, 128'd1);
    chk("s1_fill_rdata", {96'd0, proc_rdata}, {96'd0, 32'hA000_0000});
    chk("s1_fill_mem_read_dropped", {127'd0, mem_read}, 128'd0);
    tick();
    @(negedge clk);
    chk("s1_retry_stall", {127'd0, proc_stall}, 128'd0);
    chk("s1_retry_rdata", {96'd0, proc_rdata}, {96'd0, 32'hA000_0000});

    // Remaining words of the same line hit back-to-back.
    for (int w = 1; w < 4; w++) begin
      tick();
      proc_addr = 30'h10 + 30'(w);
      @(negedge clk);
      chk("s2_hit_stall", {127'd0, proc_stall}, 128'd0);
      chk("s2_hit_rdata", {96'd0, proc_rdata}, {96'd0, 32'hA000_0000 + 32'(w)});
      chk("s2_no_mem_read", {127'd0, mem_read}, 128'd0);
    end
    tick();
    proc_read = 1'b0;
    @(negedge clk);
    chk("s2_idle_rdata_holds", {96'd0, proc_rdata}, {96'd0, 32'hA000_0003});
`ifdef ICACHE_PERF_EN
    chk("s6_perf_misses", {96'd0, perf_misses}, {96'd0, 32'd1});
    chk("s6_perf_hits", {96'd0, perf_hits}, {96'd0, 32'd4});
`endif

    // Conflict: 0x30 shares index 4 with 0x10 under a new tag.
    tick();
    proc_read = 1'b1;
    proc_addr = 30'h30;
    @(negedge clk);
    chk("s3_conflict_miss", {127'd0, proc_stall}, 128'd1);
    serve(BLK_B, 2);
    @(negedge clk);
    chk("s3_fill_rdata", {96'd0, proc_rdata}, {96'd0, 32'hB000_0000});
    tick();
    @(negedge clk);
    chk("s3_hit_b", {96'd0, proc_rdata}, {96'd0, 32'hB000_0000});
    tick();
    proc_addr = 30'h10;
    @(negedge clk);
    chk("s3_evicted_misses", {127'd0, proc_stall}, 128'd1);
    serve(BLK_A, 1);
    tick();
    @(negedge clk);
    chk("s3_refill_hit", {96'd0, proc_rdata}, {96'd0, 32'hA000_0000});

    // Reset during a fetch; the late mem_ready must be ignored.
    tick();
    proc_addr = 30'h20;
    tick();
    @(negedge clk);
    chk("s4_fetching", {127'd0, mem_read}, 128'd1);
    tick();
    rst = 1'b1;
    proc_read = 1'b0;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = BLK_C;
    @(negedge clk);
    chk("s4_mem_read_dropped", {127'd0, mem_read}, 128'd0);
    chk("s4_no_stall", {127'd0, proc_stall}, 128'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    proc_read = 1'b1;
    proc_addr = 30'h10;
    @(negedge clk);
    chk("s4_miss_after_rst", {127'd0, proc_stall}, 128'd1);
    serve(BLK_A, 2);
    tick();
    tick();
    proc_addr = 30'h20;
    @(negedge clk);
    chk("s4_late_ready_ignored", {127'd0, proc_stall}, 128'd1);
    serve(BLK_C, 1);
    tick();
    @(negedge clk);
    chk("s4_line0_hit", {96'd0, proc_rdata}, {96'd0, 32'hC000_0000});

    // Writes are ignored and leave the cache untouched.
    tick();
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h10;
    @(negedge clk);
    chk("s5_write_no_stall", {127'd0, proc_stall}, 128'd0);
    chk("s5_write_no_mem_read", {127'd0, mem_read}, 128'd0);
    chk("s5_write_mem_write", {127'd0, mem_write}, 128'd0);
    tick();
    tick();
    @(negedge clk);
    chk("s5_still_idle", {127'd0, mem_read}, 128'd0);
    tick();
    proc_read = 1'b1;
    proc_addr = 30'h13;
    @(negedge clk);
    chk("s5_read_and_write_hits", {127'd0, proc_stall}, 128'd0);
    chk("s5_read_and_write_rdata", {96'd0, proc_rdata}, {96'd0, 32'hA000_0003});

    tick();
    proc_read  = 1'b0;
    proc_write = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
